// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage driving an SRAM-like bus with one outstanding request
// Optional macro IF_BEV_EN: exception vector becomes EXC_VEC_BEV instead of 32'h80000180.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter logic [31:0] EXC_VEC_BEV = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic        eret_flush,
  input  logic [31:0] epc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] IF_out_PC,
  output logic [31:0] IF_inst,
  output logic        IF_AdEF_exception,
  output logic [31:0] IF_bad_inst,
  output logic        IF_stall,
  output logic        IF_invalid
);

`ifdef IF_BEV_EN
  localparam logic [31:0] EXC_VEC = EXC_VEC_BEV;
`else
  localparam logic [31:0] EXC_VEC = 32'h80000180 | (EXC_VEC_BEV & 32'h0);
`endif

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        adef_q, adef_d;
  logic [31:0] bad_q, bad_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        discard_q, discard_d;

  logic        flush, aligned, handoff;
  logic [31:0] flush_pc, next_pc;

  assign flush    = exc_flush | eret_flush;
  assign flush_pc = exc_flush ? EXC_VEC : epc;
  assign aligned  = (fa_q[1:0] == 2'b00);
  assign handoff  = (state_q == S_HOLD) && !ID_stall && !flush;
  assign next_pc  = br_taken ? br_target : (br_pend_q ? br_tgt_q : pc_q + 32'd4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fa_d      = fa_q;
    out_pc_d  = out_pc_q;
    inst_d    = inst_q;
    adef_d    = adef_q;
    bad_d     = bad_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    discard_d = discard_q;

    if (flush) begin
      pc_d      = flush_pc;
      br_pend_d = 1'b0;
    end else if (handoff) begin
      pc_d      = next_pc;
      br_pend_d = 1'b0;
    end else if (br_taken && !ID_stall) begin
      br_pend_d = 1'b1;
      br_tgt_d  = br_target;
    end

    case (state_q)
      S_REQ: begin
        if (!aligned) begin
          if (flush) begin
            fa_d = flush_pc;
          end else begin
            state_d  = S_HOLD;
            out_pc_d = fa_q;
            inst_d   = 32'h0;
            adef_d   = 1'b1;
            bad_d    = fa_q;
          end
        end else begin
          // A request already on the bus cannot be withdrawn; its reply is dropped instead.
          if (flush) discard_d = 1'b1;
          if (inst_addr_ok) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (discard_q || flush) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
            fa_d      = pc_d;
          end else begin
            state_d  = S_HOLD;
            out_pc_d = fa_q;
            inst_d   = inst_rdata;
            adef_d   = 1'b0;
            bad_d    = 32'h0;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush || handoff) begin
          state_d = S_REQ;
          fa_d    = pc_d;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      fa_q      <= RESET_PC;
      out_pc_q  <= RESET_PC;
      inst_q    <= 32'h0;
      adef_q    <= 1'b0;
      bad_q     <= 32'h0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'h0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fa_q      <= fa_d;
      out_pc_q  <= out_pc_d;
      inst_q    <= inst_d;
      adef_q    <= adef_d;
      bad_q     <= bad_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      discard_q <= discard_d;
    end
  end

  assign inst_req          = !rst && (state_q == S_REQ) && aligned;
  assign inst_wr           = 1'b0;
  assign inst_size         = 2'b10;
  assign inst_addr         = fa_q;
  assign inst_wdata        = 32'h0;
  assign IF_out_PC         = out_pc_q;
  assign IF_inst           = inst_q;
  assign IF_AdEF_exception = adef_q;
  assign IF_bad_inst       = bad_q;
  assign IF_stall          = rst || (state_q != S_HOLD);
  assign IF_invalid        = !rst && flush;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed cycle table plus randomized bus/branch/flush run against a fetch-order model
module tb_if_stage;

`ifdef IF_BEV_EN
  localparam logic [31:0] V = 32'hbfc00380;
`else
  localparam logic [31:0] V = 32'h80000180;
`endif
  localparam logic [31:0] P0 = 32'hbfc00000;

  localparam logic [6:0] F_R = 7'h40, F_S = 7'h20, F_B = 7'h10, F_X = 7'h08,
                         F_E = 7'h04, F_A = 7'h02, F_D = 7'h01;

  logic        clk = 1'b0;
  logic        rst, ID_stall, br_taken, exc_flush, eret_flush;
  logic [31:0] br_target, epc, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        inst_req, inst_wr, IF_AdEF_exception, IF_stall, IF_invalid;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, IF_out_PC, IF_inst, IF_bad_inst;

  int ncmp = 0;
  int nerr = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .ID_stall(ID_stall), .br_taken(br_taken), .br_target(br_target),
    .exc_flush(exc_flush), .eret_flush(eret_flush), .epc(epc),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .IF_out_PC(IF_out_PC), .IF_inst(IF_inst),
    .IF_AdEF_exception(IF_AdEF_exception), .IF_bad_inst(IF_bad_inst),
    .IF_stall(IF_stall), .IF_invalid(IF_invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]  f;
    logic [31:0] d;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
    logic [31:0] bad;
    logic        inv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [6:0] f, input logic [31:0] d, input logic req,
                              input logic [31:0] addr, input logic stall, input logic [31:0] pc,
                              input logic [31:0] inst, input logic adef, input logic [31:0] bad,
                              input logic inv);
    vec_t v;
    v.f = f; v.d = d; v.req = req; v.addr = addr; v.stall = stall;
    v.pc = pc; v.inst = inst; v.adef = adef; v.bad = bad; v.inv = inv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h01234567;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = (($urandom % 10) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
    return a;
  endfunction

  task automatic drive(input logic [6:0] f, input logic [31:0] d);
    rst          = f[6];
    ID_stall     = f[5];
    br_taken     = f[4];
    exc_flush    = f[3];
    eret_flush   = f[2];
    inst_addr_ok = f[1];
    inst_data_ok = f[0];
    br_target    = d;
    epc          = d;
    inst_rdata   = d;
  endtask

  logic [31:0] pend_a[$];
  int          pend_c[$];
  logic [31:0] mpc, redir, prev_addr;
  logic        redir_v, prev_stuck, mis;
  int          handoffs;

  initial begin
    drive(F_R, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mk(F_R, 32'h0,        0, P0, 1, P0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(F_A, 32'h0,        1, P0, 1, P0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(F_D, 32'h24080001, 0, P0, 1, P0, 32'h0, 0, 32'h0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(F_S, 32'h0,      0, P0, 0, P0, 32'h24080001, 0, 32'h0, 0));
    tbl.push_back(mk(7'h0, 32'h0,       0, P0, 0, P0, 32'h24080001, 0, 32'h0, 0));
    tbl.push_back(mk(F_A, 32'h0,        1, 32'hbfc00004, 1, P0, 32'h24080001, 0, 32'h0, 0));
    tbl.push_back(mk(F_D, 32'h24090002, 0, 32'hbfc00004, 1, P0, 32'h24080001, 0, 32'h0, 0));
    tbl.push_back(mk(7'h0, 32'h0,       0, 32'hbfc00004, 0, 32'hbfc00004, 32'h24090002, 0, 32'h0, 0));
    tbl.push_back(mk(F_A, 32'h0,        1, 32'hbfc00008, 1, 32'hbfc00004, 32'h24090002, 0, 32'h0, 0));
    tbl.push_back(mk(F_B, 32'hbfc00100, 0, 32'hbfc00008, 1, 32'hbfc00004, 32'h24090002, 0, 32'h0, 0));
    tbl.push_back(mk(F_D, 32'h240a0003, 0, 32'hbfc00008, 1, 32'hbfc00004, 32'h24090002, 0, 32'h0, 0));
    tbl.push_back(mk(7'h0, 32'h0,       0, 32'hbfc00008, 0, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_A, 32'h0,        1, 32'hbfc00100, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_X, 32'h0,        0, 32'hbfc00100, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 1));
    tbl.push_back(mk(F_D, 32'hdeadbeef, 0, 32'hbfc00100, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(7'h0, 32'h0,     1, V, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_X, 32'h0,        1, V, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 1));
    tbl.push_back(mk(F_A, 32'h0,        1, V, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_D, 32'hdeadbeef, 0, V, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_A, 32'h0,        1, V, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_D, 32'h11111111, 0, V, 1, 32'hbfc00008, 32'h240a0003, 0, 32'h0, 0));
    tbl.push_back(mk(F_E, 32'hbfc00012, 0, V, 0, V, 32'h11111111, 0, 32'h0, 1));
    tbl.push_back(mk(7'h0, 32'h0,       0, 32'hbfc00012, 1, V, 32'h11111111, 0, 32'h0, 0));
    tbl.push_back(mk(F_S, 32'h0,        0, 32'hbfc00012, 0, 32'hbfc00012, 32'h0, 1, 32'hbfc00012, 0));
    tbl.push_back(mk(7'h0, 32'h0,       0, 32'hbfc00012, 0, 32'hbfc00012, 32'h0, 1, 32'hbfc00012, 0));
    tbl.push_back(mk(7'h0, 32'h0,       0, 32'hbfc00016, 1, 32'hbfc00012, 32'h0, 1, 32'hbfc00012, 0));
    tbl.push_back(mk(F_X, 32'h0,        0, 32'hbfc00016, 0, 32'hbfc00016, 32'h0, 1, 32'hbfc00016, 1));
    tbl.push_back(mk(F_A, 32'h0,        1, V, 1, 32'hbfc00016, 32'h0, 1, 32'hbfc00016, 0));
    tbl.push_back(mk(F_R, 32'h0,        0, V, 1, 32'hbfc00016, 32'h0, 1, 32'hbfc00016, 0));
    tbl.push_back(mk(F_D, 32'hdeadbeef, 1, P0, 1, P0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(F_A, 32'h0,        1, P0, 1, P0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(F_D, 32'h33333333, 0, P0, 1, P0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(F_S, 32'h0,        0, P0, 0, P0, 32'h33333333, 0, 32'h0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].f, tbl[i].d);
      @(negedge clk);
      chk($sformatf("row%0d inst_req", i),  32'(inst_req),          32'(tbl[i].req));
      chk($sformatf("row%0d inst_addr", i), inst_addr,              tbl[i].addr);
      chk($sformatf("row%0d IF_stall", i),  32'(IF_stall),          32'(tbl[i].stall));
      chk($sformatf("row%0d IF_out_PC", i), IF_out_PC,              tbl[i].pc);
      chk($sformatf("row%0d IF_inst", i),   IF_inst,                tbl[i].inst);
      chk($sformatf("row%0d AdEF", i),      32'(IF_AdEF_exception), 32'(tbl[i].adef));
      chk($sformatf("row%0d bad_inst", i),  IF_bad_inst,            tbl[i].bad);
      chk($sformatf("row%0d IF_invalid", i), 32'(IF_invalid),       32'(tbl[i].inv));
      chk($sformatf("row%0d bus consts", i), {inst_wdata[29:0], inst_wr, inst_size[0]},
          32'h0);
      @(posedge clk);
      #1;
    end

    // Randomized run: fetch-order model fed by a bus slave with random handshake delays.
    drive(F_R, 32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mpc        = P0;
    redir      = 32'h0;
    redir_v    = 1'b0;
    prev_stuck = 1'b0;
    prev_addr  = 32'h0;
    handoffs   = 0;
    for (int c = 0; c < 4000; c++) begin
      ID_stall     = ($urandom % 4) == 0;
      br_taken     = ($urandom % 6) == 0;
      br_target    = rnd_addr();
      exc_flush    = ($urandom % 60) == 0;
      eret_flush   = ($urandom % 60) == 0;
      epc          = rnd_addr();
      inst_addr_ok = ($urandom % 3) != 0;
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (pend_a.size() != 0 && pend_c[0] < c && ($urandom % 2) == 1) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem(pend_a.pop_front());
        void'(pend_c.pop_front());
      end
      @(negedge clk);
      chk("rnd IF_invalid", 32'(IF_invalid), 32'(exc_flush | eret_flush));
      if (prev_stuck) begin
        chk("rnd req held", 32'(inst_req), 32'h1);
        chk("rnd addr held", inst_addr, prev_addr);
      end
      if (pend_a.size() != 0) chk("rnd one outstanding", 32'(inst_req), 32'h0);
      if (inst_req && inst_addr_ok) begin
        pend_a.push_back(inst_addr);
        pend_c.push_back(c);
      end
      prev_stuck = inst_req && !inst_addr_ok;
      prev_addr  = inst_addr;

      if (exc_flush || eret_flush) begin
        mpc     = exc_flush ? V : epc;
        redir_v = 1'b0;
      end else if (!IF_stall && !ID_stall) begin
        mis = (mpc[1:0] != 2'b00);
        chk("rnd handoff PC", IF_out_PC, mpc);
        chk("rnd handoff inst", IF_inst, mis ? 32'h0 : mem(mpc));
        chk("rnd handoff AdEF", 32'(IF_AdEF_exception), 32'(mis));
        chk("rnd handoff bad", IF_bad_inst, mis ? mpc : 32'h0);
        handoffs++;
        mpc     = br_taken ? br_target : (redir_v ? redir : mpc + 32'd4);
        redir_v = 1'b0;
      end else if (br_taken && !ID_stall) begin
        redir   = br_target;
        redir_v = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("rnd progress", 32'(handoffs > 150), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
